// File: rtl/axis_csum_pkg.sv
// Shared checksum definitions for the action-pipe checksum engines.
// Holds the mode encoding and the one's-complement helpers.
package axis_csum_pkg;

  localparam int unsigned CSUM_WIDTH = 16;

  typedef enum logic {
    CSUM_MODE_GEN = 1'b0,
    CSUM_MODE_VER = 1'b1
  } csum_mode_e;

  // Convert between a little-endian byte pair in tdata and a network-order word.
  function automatic logic [15:0] byte_swap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  // Two end-around carries are enough for any sum of up to 65536 words.
  function automatic logic [15:0] ones_fold(input logic [31:0] s);
    logic [31:0] t;
    t = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    t = {16'h0, t[15:0]} + {16'h0, t[31:16]};
    return t[15:0];
  endfunction

endpackage

// File: rtl/csum_adder_tree.sv
// Combinational one's-complement sum of NUM_WORDS 16-bit words, folded to 16 bits.
// Reusable by the pseudo-header checksum engines.
module csum_adder_tree
  import axis_csum_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 10
) (
  input  logic [NUM_WORDS*CSUM_WIDTH-1:0] words,
  output logic [CSUM_WIDTH-1:0]           fold
);

  localparam int unsigned SUM_WIDTH = CSUM_WIDTH + $clog2(NUM_WORDS);

  logic [SUM_WIDTH-1:0] sum;

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      sum = sum + SUM_WIDTH'(words[i*CSUM_WIDTH +: CSUM_WIDTH]);
    end
    fold = ones_fold(32'(sum));
  end

endmodule

// File: rtl/axis_csum_engine.sv
// Header checksum generate/verify engine on an AXI-Stream, two register stages.
// The first beat of each packet carries the header; later beats pass untouched.
module axis_csum_engine
  import axis_csum_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEST_WIDTH = 4,
  parameter int unsigned USER_WIDTH = 4,
  parameter int unsigned HDR_BYTES  = 20,
  parameter int unsigned ENABLE     = 1,
  parameter int unsigned OFF_WIDTH  = $clog2(KEEP_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csum_enable,
  input  logic                  csum_mode,
  input  logic [OFF_WIDTH-1:0]  csum_start,
  input  logic [OFF_WIDTH-1:0]  csum_offset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_stat_valid,
  output logic                  m_stat_ok,
  output logic                  m_stat_err
);

  localparam int unsigned HDR_WORDS = HDR_BYTES / 2;

  if (ENABLE == 0) begin : g_bypass
    assign s_axis_tready = m_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tvalid = s_axis_tvalid;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tid    = s_axis_tid;
    assign m_axis_tdest  = s_axis_tdest;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_stat_valid  = 1'b0;
    assign m_stat_ok     = 1'b0;
    assign m_stat_err    = 1'b0;
  end else begin : g_pipe
    logic                            out_ready, s_fire, in_frame;
    logic                            in_err;
    logic [31:0]                     start_w, off_w, idx;
    logic [KEEP_WIDTH-1:0]           hdr_mask;
    logic [HDR_WORDS*CSUM_WIDTH-1:0] in_words;

    logic                            s1_valid, s1_hdr, s1_err, s1_last;
    csum_mode_e                      s1_mode;
    logic [OFF_WIDTH-1:0]            s1_off;
    logic [HDR_WORDS*CSUM_WIDTH-1:0] s1_words;
    logic [DATA_WIDTH-1:0]           s1_data;
    logic [KEEP_WIDTH-1:0]           s1_keep;
    logic [ID_WIDTH-1:0]             s1_id;
    logic [DEST_WIDTH-1:0]           s1_dest;
    logic [USER_WIDTH-1:0]           s1_user;

    logic [CSUM_WIDTH-1:0]           s1_fold, csum;
    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_ok, out_err;

    assign out_ready     = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = !s1_valid || out_ready;
    assign s_fire        = s_axis_tvalid && s_axis_tready;

    always_comb begin
      start_w  = 32'(csum_start);
      off_w    = 32'(csum_offset);
      hdr_mask = KEEP_WIDTH'({HDR_BYTES{1'b1}}) << csum_start;
      in_err   = start_w[0] || off_w[0] ||
                 (start_w + HDR_BYTES > KEEP_WIDTH) ||
                 (off_w < start_w) || (off_w > start_w + HDR_BYTES - 2) ||
                 ((s_axis_tkeep & hdr_mask) != hdr_mask);
      idx      = '0;
      in_words = '0;
      // In generate mode the checksum field is summed as zero.
      for (int unsigned i = 0; i < HDR_WORDS; i++) begin
        idx = start_w + 2 * i;
        if (idx + 2 <= KEEP_WIDTH &&
            !(csum_mode == CSUM_MODE_GEN && idx == off_w)) begin
          in_words[i*CSUM_WIDTH +: CSUM_WIDTH] = byte_swap16(s_axis_tdata[8*idx +: 16]);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        in_frame <= 1'b0;
        s1_valid <= 1'b0;
      end else begin
        if (s_fire) in_frame <= !s_axis_tlast;
        if (s_axis_tready) s1_valid <= s_axis_tvalid;
      end
    end

    always_ff @(posedge clk) begin
      if (s_fire) begin
        s1_hdr   <= !in_frame && csum_enable;
        s1_mode  <= csum_mode_e'(csum_mode);
        s1_err   <= in_err;
        s1_off   <= csum_offset;
        s1_words <= in_words;
        s1_data  <= s_axis_tdata;
        s1_keep  <= s_axis_tkeep;
        s1_last  <= s_axis_tlast;
        s1_id    <= s_axis_tid;
        s1_dest  <= s_axis_tdest;
        s1_user  <= s_axis_tuser;
      end
    end

    csum_adder_tree #(
      .NUM_WORDS(HDR_WORDS)
    ) u_tree (
      .words(s1_words),
      .fold (s1_fold)
    );

    assign csum = ~s1_fold;

    always_comb begin
      out_data = s1_data;
      out_ok   = 1'b0;
      out_err  = 1'b0;
      if (s1_hdr) begin
        if (s1_err) begin
          out_err = 1'b1;
        end else if (s1_mode == CSUM_MODE_GEN) begin
          out_ok = 1'b1;
          out_data[8*32'(s1_off) +: 16] = byte_swap16(csum);
        end else begin
          out_ok = (s1_fold == 16'hFFFF);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_axis_tkeep  <= '0;
        m_axis_tlast  <= 1'b0;
        m_axis_tid    <= '0;
        m_axis_tdest  <= '0;
        m_axis_tuser  <= '0;
        m_stat_valid  <= 1'b0;
        m_stat_ok     <= 1'b0;
        m_stat_err    <= 1'b0;
      end else if (out_ready) begin
        m_axis_tvalid <= s1_valid;
        if (s1_valid) begin
          m_axis_tdata <= out_data;
          m_axis_tkeep <= s1_keep;
          m_axis_tlast <= s1_last;
          m_axis_tid   <= s1_id;
          m_axis_tdest <= s1_dest;
          m_axis_tuser <= s1_user;
          m_stat_valid <= s1_hdr;
          m_stat_ok    <= out_ok;
          m_stat_err   <= out_err;
        end else begin
          m_stat_valid <= 1'b0;
          m_stat_ok    <= 1'b0;
          m_stat_err   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_csum_engine.sv
// Randomised self-checking bench for axis_csum_engine against a byte-level checksum model.
module tb_axis_csum_engine;

  localparam int DW  = 512;
  localparam int KW  = 64;
  localparam int IW  = 8;
  localparam int DSW = 4;
  localparam int UW  = 4;
  localparam int HB  = 20;
  localparam int OW  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          csum_enable, csum_mode;
  logic [OW-1:0] csum_start, csum_offset;
  logic [DW-1:0] s_tdata, m_tdata;
  logic [KW-1:0] s_tkeep, m_tkeep;
  logic          s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
  logic [IW-1:0] s_tid, m_tid;
  logic [DSW-1:0] s_tdest, m_tdest;
  logic [UW-1:0] s_tuser, m_tuser;
  logic          m_stat_valid, m_stat_ok, m_stat_err;

  axis_csum_engine #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
    .USER_WIDTH(UW), .HDR_BYTES(HB), .ENABLE(1), .OFF_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst),
    .csum_enable(csum_enable), .csum_mode(csum_mode),
    .csum_start(csum_start), .csum_offset(csum_offset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .m_stat_valid(m_stat_valid), .m_stat_ok(m_stat_ok), .m_stat_err(m_stat_err)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
    logic           sv, ok, err;
    int             acc;
  } exp_t;

  exp_t        expq[$];
  int          errors = 0, checks = 0;
  int          cyc = 0, stall_cnt = 0, out_cnt = 0, stat_cnt = 0;
  int          ready_mode = 0;
  logic        lat_check = 1'b0;
  logic        mdl_in_frame = 1'b0;
  logic [DW-1:0] last_data;
  logic [2:0]  last_stat;
  logic [7:0]  ipv4_hdr [HB];

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // Random beat with the reference IPv4 header at byte 14 and cs at bytes 24/25.
  function automatic logic [DW-1:0] ipv4_beat(input logic [15:0] cs);
    logic [DW-1:0] d;
    d = rand_data();
    for (int i = 0; i < HB; i++) d[8*(14+i) +: 8] = ipv4_hdr[i];
    d[8*24 +: 8] = cs[15:8];
    d[8*25 +: 8] = cs[7:0];
    return d;
  endfunction

  // Reference: plain integer one's-complement arithmetic over a byte array.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                 input logic hdr, input logic en, input logic mode,
                                 input int start, input int off);
    exp_t e;
    logic [7:0] b [KW];
    int sum, w;
    logic bad;
    for (int i = 0; i < KW; i++) b[i] = d[8*i +: 8];
    e.data = d; e.keep = k; e.last = 0; e.id = 0; e.dest = 0; e.user = 0;
    e.sv = 0; e.ok = 0; e.err = 0; e.acc = 0;
    if (!(hdr && en)) return e;
    e.sv = 1;
    bad = (start % 2 != 0) || (start + HB > KW) || (off % 2 != 0) ||
          (off < start) || (off > start + HB - 2);
    if (!bad) for (int i = 0; i < HB; i++) if (!k[start+i]) bad = 1;
    if (bad) begin
      e.err = 1;
      return e;
    end
    sum = 0;
    for (int i = 0; i < HB; i += 2)
      if (!(mode == 1'b0 && start + i == off)) sum += {b[start+i], b[start+i+1]};
    while (sum > 'hffff) sum = (sum & 'hffff) + (sum >> 16);
    if (mode == 1'b0) begin
      w = ~sum & 'hffff;
      b[off]   = w[15:8];
      b[off+1] = w[7:0];
      e.ok = 1;
      for (int i = 0; i < KW; i++) e.data[8*i +: 8] = b[i];
    end else begin
      e.ok = (sum == 'hffff);
    end
    return e;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last,
                           input logic en, input logic mode, input int start, input int off);
    exp_t e;
    int waitc = 0;
    s_tdata = d; s_tkeep = k; s_tlast = last;
    s_tid = IW'($urandom); s_tdest = DSW'($urandom); s_tuser = UW'($urandom);
    csum_enable = en; csum_mode = mode;
    csum_start = OW'(start); csum_offset = OW'(off);
    s_tvalid = 1'b1;
    #1;
    while (!s_tready) begin
      @(negedge clk); #1;
      stall_cnt++; waitc++;
      if (waitc > 1000) begin
        check_val("tready_timeout", 0, 1);
        s_tvalid = 1'b0;
        return;
      end
    end
    e = model(d, k, !mdl_in_frame, en, mode, start, off);
    e.last = last; e.id = s_tid; e.dest = s_tdest; e.user = s_tuser; e.acc = cyc;
    expq.push_back(e);
    mdl_in_frame = !last;
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 512'(expq.size()), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: m_tready = 1'b1;
        1: m_tready = ~m_tready;
        2: m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst && m_tvalid && m_tready) begin
        if (expq.size() == 0) begin
          check_val("unexpected_beat", 1, 0);
        end else begin
          e = expq.pop_front();
          check_val("tdata", m_tdata, e.data);
          check_val("tkeep", m_tkeep, e.keep);
          check_val("sideband", {m_tlast, m_tid, m_tdest, m_tuser}, {e.last, e.id, e.dest, e.user});
          check_val("stat", {m_stat_valid, m_stat_ok, m_stat_err}, {e.sv, e.ok, e.err});
          if (lat_check) check_val("latency", 512'(cyc - e.acc), 2);
          last_data = m_tdata;
          last_stat = {m_stat_valid, m_stat_ok, m_stat_err};
          out_cnt++;
          if (m_stat_valid) stat_cnt++;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    exp_t g;
    int o0, s0, st, of, len;
    logic en, md;

    ipv4_hdr = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                 8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};
    s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tlast = 0; s_tid = '0; s_tdest = '0; s_tuser = '0;
    csum_enable = 0; csum_mode = 0; csum_start = '0; csum_offset = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_tvalid", m_tvalid, 0);
    check_val("rst_tdata", m_tdata, 0);
    check_val("rst_stat", {m_stat_valid, m_stat_ok, m_stat_err}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_tready", s_tready, 1);

    // Generate and verify on the reference IPv4 header
    lat_check = 1;
    send_beat(ipv4_beat(16'h0000), '1, 1, 1, 0, 14, 24);
    drain();
    check_val("ipv4_gen_csum", {last_data[8*24 +: 8], last_data[8*25 +: 8]}, 16'hB861);
    check_val("ipv4_gen_stat", last_stat, 3'b110);
    d = ipv4_beat(16'hB861);
    send_beat(d, '1, 1, 1, 1, 14, 24);
    drain();
    check_val("ver_good_data", last_data, d);
    check_val("ver_good_stat", last_stat, 3'b110);
    d = ipv4_beat(16'hB860);
    send_beat(d, '1, 1, 1, 1, 14, 24);
    drain();
    check_val("ver_bad_data", last_data, d);
    check_val("ver_bad_stat", last_stat, 3'b100);

    // Multi-beat under alternating backpressure
    lat_check = 0; ready_mode = 1;
    o0 = out_cnt; s0 = stat_cnt;
    send_beat(ipv4_beat(16'h0), '1, 0, 1, 0, 14, 24);
    for (int i = 0; i < 3; i++) send_beat(rand_data(), '1, i == 2, 1, 1'($urandom), 0, 2);
    send_beat(ipv4_beat(16'h0), '1, 1, 1, 0, 14, 24);
    drain();
    check_val("mb_beats", 512'(out_cnt - o0), 5);
    check_val("mb_stats", 512'(stat_cnt - s0), 2);

    // Range and keep errors leave data untouched
    ready_mode = 0;
    d = ipv4_beat(16'h0);
    send_beat(d, '1, 1, 1, 0, 50, 52);
    drain();
    check_val("err_start_data", last_data, d);
    check_val("err_start_stat", last_stat, 3'b101);
    send_beat(d, '1, 1, 1, 0, 14, 13);
    drain();
    check_val("err_off_stat", last_stat, 3'b101);
    k = '1; k[20] = 1'b0;
    send_beat(d, k, 1, 1, 0, 14, 24);
    drain();
    check_val("err_keep_data", last_data, d);
    check_val("err_keep_stat", last_stat, 3'b101);
    d = ipv4_beat(16'h0);
    send_beat(d, '1, 1, 0, 0, 14, 24);
    drain();
    check_val("dis_data", last_data, d);
    check_val("dis_stat", last_stat, 3'b000);

    // 100 back-to-back single-beat packets, full throughput
    lat_check = 1; stall_cnt = 0; o0 = out_cnt;
    for (int i = 0; i < 100; i++) begin
      st = 2 * $urandom_range(0, 22);
      of = st + 2 * $urandom_range(0, 9);
      en = ($urandom_range(0, 4) != 0);
      md = 1'($urandom);
      d = rand_data();
      if (md && $urandom_range(0, 1) == 1) begin
        g = model(d, '1, 1, 1, 0, st, of);
        d = g.data;
      end
      send_beat(d, '1, 1, en, md, st, of);
    end
    drain();
    check_val("tp_stalls", 512'(stall_cnt), 0);
    check_val("tp_beats", 512'(out_cnt - o0), 100);

    // Random packets, random backpressure, unconstrained offsets
    lat_check = 0; ready_mode = 2;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        k = '1;
        if ($urandom_range(0, 7) == 0) k[$urandom_range(0, KW-1)] = 1'b0;
        send_beat(rand_data(), k, b == len - 1, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                  2 * $urandom_range(0, 31), $urandom_range(0, 63));
      end
    end
    drain();

    // Reset during beat 2 of a 3-beat packet
    ready_mode = 0;
    send_beat(ipv4_beat(16'h0), '1, 0, 1, 0, 14, 24);
    s_tdata = rand_data(); s_tlast = 0; s_tvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_tvalid", m_tvalid, 0);
    expq.delete();
    mdl_in_frame = 1'b0;
    rst = 1'b0; s_tvalid = 1'b0;
    @(negedge clk);
    send_beat(ipv4_beat(16'h0), '1, 1, 1, 0, 14, 24);
    drain();
    check_val("post_rst_csum", {last_data[8*24 +: 8], last_data[8*25 +: 8]}, 16'hB861);
    check_val("post_rst_stat", last_stat, 3'b110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
